// File: rtl/vlx_pkg.sv
// Shared constants, status layout and flush-state type for the VLX bit packer.
package vlx_pkg;

  localparam logic [1:0] VLX_SPR_CTRL = 2'd0;
  localparam logic [1:0] VLX_SPR_CNT  = 2'd1;
  localparam logic [1:0] VLX_SPR_ADDR = 2'd2;

  // Status word (SPR0) bit positions and control-write bits
  localparam int ST_ERR       = 31;
  localparam int ST_BUSY      = 30;
  localparam int ST_LVL_LSB   = 14;
  localparam int ST_CNT_LSB   = 0;
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_ERR_CLR = 1;

  typedef enum logic [1:0] {IDLE, PAD, DRAIN} vlx_flush_t;

  function automatic logic [31:0] vlx_mask(input logic [5:0] n);
    logic [32:0] m;
    m = (33'd1 << n) - 33'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/or1200_vlx_packer_if.sv
// CPU-facing bundle of the packer: code append, SPR access, stall and byte store path.
interface or1200_vlx_packer_if #(parameter int MAX_BITS = 16);
  localparam int NBW = $clog2(MAX_BITS + 1);

  logic            set_bit_op_i;
  logic [NBW-1:0]  num_bits_to_write_i;
  logic [31:0]     dat_i;
  logic            spr_cs;
  logic            spr_write;
  logic [1:0]      spr_addr;
  logic [31:0]     spr_dat_i;
  logic [31:0]     spr_dat_o;
  logic            stall_cpu_o;
  logic [31:0]     vlx_addr_o;
  logic [31:0]     dat_o;
  logic            store_byte_o;
  logic            ack_i;

  modport slave (
    input  set_bit_op_i, num_bits_to_write_i, dat_i, spr_cs, spr_write, spr_addr, spr_dat_i, ack_i,
    output spr_dat_o, stall_cpu_o, vlx_addr_o, dat_o, store_byte_o
  );

  modport master (
    output set_bit_op_i, num_bits_to_write_i, dat_i, spr_cs, spr_write, spr_addr, spr_dat_i, ack_i,
    input  spr_dat_o, stall_cpu_o, vlx_addr_o, dat_o, store_byte_o
  );
endinterface

// File: rtl/vlx_byte_fifo.sv
// Synchronous byte FIFO; simultaneous push and pop both take effect.
module vlx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               dat_i,
  input  logic                     pop_i,
  output logic [7:0]               dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dat_o   = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + (AW+1)'(1);
      else if (do_pop && !do_push) level_q <= level_q - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/or1200_vlx_packer.sv
// Packs MSB-first variable-length codes into bytes (optional 0xFF stuffing), queues them
// and stores them one per ack; stalls the CPU only when the accumulator or a flush blocks.
module or1200_vlx_packer
  import vlx_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int MAX_BITS   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STUFF_EN   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  or1200_vlx_packer_if.slave   bus
);
  localparam int BCW       = $clog2(ACC_W + 1);
  localparam int LVW       = $clog2(FIFO_DEPTH) + 1;
  localparam int NEED_FREE = (STUFF_EN != 0) ? 2 : 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             pend_q;
  logic [5:0]       pend_n_q;
  logic [31:0]      pend_dat_q;
  logic             stuff_q, stuff_d;
  logic             gap_q;
  logic             err_q;
  logic [31:0]      addr_q, byte_cnt_q;
  vlx_flush_t       state_q;

  logic [5:0]  op_n, app_n, pad_n;
  logic [2:0]  pad_r;
  logic [31:0] app_dat, app_code;
  logic        op_req, room, idle_st, take_new, take_pend, latch_op;
  logic        emit, push, pop, drain_done;
  logic [7:0]  emit_byte, push_dat, f_dat;
  logic        f_full, f_empty;
  logic [LVW-1:0] f_level;
  logic        spr_wr, ctrl_wr, addr_wr, wr_ok;
  logic [31:0] status;

  assign op_n      = 6'(bus.num_bits_to_write_i);
  assign op_req    = bus.set_bit_op_i && (op_n != 6'd0);
  assign room      = (bit_cnt_q <= BCW'(ACC_W - MAX_BITS));
  assign idle_st   = (state_q == IDLE);
  assign take_new  = op_req && !pend_q && idle_st && room;
  assign take_pend = pend_q && idle_st && room;
  assign latch_op  = op_req && !pend_q && !take_new;
  assign pad_r     = 3'd0 - bit_cnt_q[2:0];
  assign pad_n     = {3'b000, pad_r};

  always_comb begin
    app_n   = '0;
    app_dat = '0;
    if (state_q == PAD) begin
      app_n   = pad_n;
      app_dat = '1;
    end else if (take_pend) begin
      app_n   = pend_n_q;
      app_dat = pend_dat_q;
    end else if (take_new) begin
      app_n   = op_n;
      app_dat = bus.dat_i;
    end
  end

  // A pending stuff byte blocks emission; reserving two free slots guarantees it a place.
  assign app_code  = app_dat & vlx_mask(app_n);
  assign emit_byte = 8'(acc_q >> (bit_cnt_q - BCW'(8)));
  assign emit      = (bit_cnt_q >= BCW'(8)) && !stuff_q && (int'(f_level) + NEED_FREE <= FIFO_DEPTH);
  assign push      = emit || (stuff_q && !f_full);
  assign push_dat  = stuff_q ? 8'h00 : emit_byte;
  assign acc_d     = (acc_q << app_n) | ACC_W'(app_code);
  assign bit_cnt_d = bit_cnt_q + BCW'(app_n) - (emit ? BCW'(8) : BCW'(0));
  assign stuff_d   = stuff_q ? f_full : ((STUFF_EN != 0) && emit && (emit_byte == 8'hFF));

  assign pop        = bus.store_byte_o && bus.ack_i;
  assign drain_done = (bit_cnt_q == '0) && !stuff_q &&
                      (f_empty || ((f_level == LVW'(1)) && pop));

  assign spr_wr  = bus.spr_cs && bus.spr_write;
  assign ctrl_wr = spr_wr && (bus.spr_addr == VLX_SPR_CTRL);
  assign addr_wr = spr_wr && (bus.spr_addr == VLX_SPR_ADDR);
  assign wr_ok   = (bit_cnt_q < BCW'(8)) && f_empty && idle_st;

  vlx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .dat_i   (push_dat),
    .pop_i   (pop),
    .dat_o   (f_dat),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (f_level)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      pend_q     <= 1'b0;
      pend_n_q   <= '0;
      pend_dat_q <= '0;
      stuff_q    <= 1'b0;
      gap_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      stuff_q   <= stuff_d;
      gap_q     <= pop;
      if (take_pend) begin
        pend_q <= 1'b0;
      end else if (latch_op) begin
        pend_q     <= 1'b1;
        pend_n_q   <= op_n;
        pend_dat_q <= bus.dat_i;
      end
      if (pop) begin
        addr_q     <= addr_q + 32'd1;
        byte_cnt_q <= byte_cnt_q + 32'd1;
      end
      if (addr_wr) begin
        if (wr_ok) begin
          addr_q     <= bus.spr_dat_i;
          byte_cnt_q <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end else if (ctrl_wr && bus.spr_dat_i[CTRL_ERR_CLR]) begin
        err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ctrl_wr && bus.spr_dat_i[CTRL_FLUSH]) state_q <= PAD;
        PAD:     state_q <= DRAIN;
        DRAIN:   if (drain_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    status                       = '0;
    status[ST_ERR]               = err_q;
    status[ST_BUSY]              = !idle_st;
    status[ST_LVL_LSB +: 8]      = 8'(f_level);
    status[ST_CNT_LSB +: 6]      = 6'(bit_cnt_q);
    case (bus.spr_addr)
      VLX_SPR_CTRL: bus.spr_dat_o = status;
      VLX_SPR_CNT:  bus.spr_dat_o = byte_cnt_q;
      VLX_SPR_ADDR: bus.spr_dat_o = addr_q;
      default:      bus.spr_dat_o = '0;
    endcase
  end

  assign bus.stall_cpu_o  = !idle_st || pend_q || (op_req && !take_new);
  assign bus.store_byte_o = !f_empty && !gap_q;
  assign bus.dat_o        = {24'b0, f_dat};
  assign bus.vlx_addr_o   = addr_q;
endmodule

// File: tb/tb_or1200_vlx_packer.sv
// Directed bench: dut0 stuffs 0xFF, dut1 (no stuffing) mirrors its CPU/SPR inputs with its own store ack.
module tb_or1200_vlx_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  bit   auto0 = 1'b0;
  bit   auto1 = 1'b1;
  logic [39:0] q0[$];
  logic [39:0] q1[$];

  always #5 clk = ~clk;

  or1200_vlx_packer_if #(.MAX_BITS(16)) bus0();
  or1200_vlx_packer_if #(.MAX_BITS(16)) bus1();

  or1200_vlx_packer dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  or1200_vlx_packer #(.STUFF_EN(0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  assign bus1.set_bit_op_i        = bus0.set_bit_op_i;
  assign bus1.num_bits_to_write_i = bus0.num_bits_to_write_i;
  assign bus1.dat_i               = bus0.dat_i;
  assign bus1.spr_cs              = bus0.spr_cs;
  assign bus1.spr_write           = bus0.spr_write;
  assign bus1.spr_addr            = bus0.spr_addr;
  assign bus1.spr_dat_i           = bus0.spr_dat_i;

  // Store-side responders: record {addr, byte} and ack one cycle.
  always @(negedge clk) begin
    if (auto0) begin
      if (bus0.ack_i) bus0.ack_i = 1'b0;
      else if (bus0.store_byte_o) begin
        q0.push_back({bus0.vlx_addr_o, bus0.dat_o[7:0]});
        bus0.ack_i = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (auto1) begin
      if (bus1.ack_i) bus1.ack_i = 1'b0;
      else if (bus1.store_byte_o) begin
        q1.push_back({bus1.vlx_addr_o, bus1.dat_o[7:0]});
        bus1.ack_i = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_bit(input logic [4:0] n, input logic [31:0] d, output logic st);
    @(negedge clk);
    bus0.set_bit_op_i        = 1'b1;
    bus0.num_bits_to_write_i = n;
    bus0.dat_i               = d;
    #1 st = bus0.stall_cpu_o;
    @(negedge clk);
    bus0.set_bit_op_i = 1'b0;
  endtask

  task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus0.spr_cs    = 1'b1;
    bus0.spr_write = 1'b1;
    bus0.spr_addr  = a;
    bus0.spr_dat_i = d;
    @(negedge clk);
    bus0.spr_cs    = 1'b0;
    bus0.spr_write = 1'b0;
    bus0.spr_addr  = 2'd0;
  endtask

  task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
    bus0.spr_addr = a;
    #1 d = bus0.spr_dat_o;
    bus0.spr_addr = 2'd0;
  endtask

  task automatic wait_nostall(input int budget);
    for (int k = 0; k < budget && bus0.stall_cpu_o; k++) @(negedge clk);
  endtask

  initial begin
    logic        st;
    logic [31:0] r;
    int          first_stall;
    int          timeouts;
    bit          released;
    int          i;

    bus0.set_bit_op_i = 1'b0; bus0.num_bits_to_write_i = '0; bus0.dat_i = '0;
    bus0.spr_cs = 1'b0; bus0.spr_write = 1'b0; bus0.spr_addr = 2'd0; bus0.spr_dat_i = '0;
    bus0.ack_i = 1'b0; bus1.ack_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_store", 32'(bus0.store_byte_o), 0);
    chk("rst_stall", 32'(bus0.stall_cpu_o), 0);
    chk("rst_addr", bus0.vlx_addr_o, 0);
    chk("rst_dat", bus0.dat_o, 0);
    spr_rd(2'd0, r); chk("rst_spr0", r, 0);
    spr_rd(2'd1, r); chk("rst_spr1", r, 0);

    // Two nibbles form one byte
    auto0 = 1'b1;
    spr_wr(2'd2, 32'h1000);
    set_bit(5'd4, 32'hFFFF_FFFA, st); chk("a5_stall0", 32'(st), 0);
    wait_nostall(20);
    set_bit(5'd4, 32'h5, st); chk("a5_stall1", 32'(st), 0);
    i = 0; while (q0.size() < 1 && i < 50) begin @(negedge clk); i++; end
    chk("a5_count", q0.size(), 1);
    if (q0.size() >= 1) chk("a5_store", q0[0], {32'h1000, 8'hA5});
    repeat (2) @(negedge clk);
    spr_rd(2'd1, r); chk("a5_bytecnt", r, 1);
    chk("a5_idle", 32'(bus0.store_byte_o), 0);

    // 0xFF stuffing on dut0, none on dut1
    spr_wr(2'd2, 32'h1000);
    q0.delete(); q1.delete();
    set_bit(5'd8, 32'hFF, st); wait_nostall(20);
    set_bit(5'd8, 32'h12, st); wait_nostall(20);
    i = 0; while ((q0.size() < 3 || q1.size() < 2) && i < 100) begin @(negedge clk); i++; end
    chk("stuff_count", q0.size(), 3);
    chk("nostuff_count", q1.size(), 2);
    if (q0.size() >= 3) begin
      chk("stuff_b0", q0[0], {32'h1000, 8'hFF});
      chk("stuff_b1", q0[1], {32'h1001, 8'h00});
      chk("stuff_b2", q0[2], {32'h1002, 8'h12});
    end
    if (q1.size() >= 2) begin
      chk("nostuff_b0", q1[0], {32'h1000, 8'hFF});
      chk("nostuff_b1", q1[1], {32'h1001, 8'h12});
    end
    repeat (3) @(negedge clk);
    spr_rd(2'd1, r); chk("stuff_bytecnt", r, 3);

    // Flush pads 101 with ones -> 0xBF
    auto0 = 1'b0;
    set_bit(5'd3, 32'h5, st); chk("flush_op_stall", 32'(st), 0);
    spr_wr(2'd0, 32'h1);
    chk("flush_stall", 32'(bus0.stall_cpu_o), 1);
    spr_rd(2'd0, r); chk("flush_busy", r[30], 1);
    i = 0; while (!bus0.store_byte_o && i < 50) begin @(negedge clk); i++; end
    chk("flush_store", 32'(bus0.store_byte_o), 1);
    chk("flush_byte", bus0.dat_o, 32'hBF);
    chk("flush_addr", bus0.vlx_addr_o, 32'h1003);
    chk("flush_stall_held", 32'(bus0.stall_cpu_o), 1);
    bus0.ack_i = 1'b1;
    @(negedge clk);
    bus0.ack_i = 1'b0;
    chk("flush_stall_clr", 32'(bus0.stall_cpu_o), 0);
    spr_rd(2'd0, r); chk("flush_done_spr0", r, 0);

    // Address write while bytes are queued is rejected
    spr_wr(2'd2, 32'h2000);
    chk("addr_set", bus0.vlx_addr_o, 32'h2000);
    set_bit(5'd8, 32'h77, st);
    i = 0; while (!bus0.store_byte_o && i < 50) begin @(negedge clk); i++; end
    chk("err_byte", bus0.dat_o, 32'h77);
    spr_wr(2'd2, 32'h3000);
    spr_rd(2'd0, r); chk("err_set", r, 32'h8000_4000);
    chk("err_addr", bus0.vlx_addr_o, 32'h2000);
    spr_wr(2'd0, 32'h2);
    spr_rd(2'd0, r); chk("err_clr", r, 32'h0000_4000);
    q0.delete();
    auto0 = 1'b1;
    i = 0; while (q0.size() < 1 && i < 50) begin @(negedge clk); i++; end
    if (q0.size() >= 1) chk("err_drain", q0[0], {32'h2000, 8'h77});
    else chk("err_drain_count", q0.size(), 1);
    repeat (3) @(negedge clk);

    // Withheld ack: FIFO and accumulator fill, stall, then everything drains in order
    auto0 = 1'b0;
    q0.delete();
    first_stall = -1; timeouts = 0; released = 1'b0;
    for (int n = 0; n < 10; n++) begin
      set_bit(5'd16, 32'h1234, st);
      if (st && first_stall < 0) first_stall = n;
      for (int k = 0; k < 100 && bus0.stall_cpu_o; k++) begin
        @(negedge clk);
        if (k == 8 && !released) begin
          spr_rd(2'd0, r); chk("fill_status", r, 32'h0000_C018);
          released = 1'b1;
          auto0 = 1'b1;
        end
      end
      if (bus0.stall_cpu_o) timeouts++;
    end
    auto0 = 1'b1;
    chk("first_stall", 32'(first_stall), 3);
    chk("op_timeouts", 32'(timeouts), 0);
    i = 0; while (q0.size() < 20 && i < 1000) begin @(negedge clk); i++; end
    chk("fill_count", q0.size(), 20);
    for (int k = 0; k < 20 && k < q0.size(); k++) begin
      logic [7:0] exp_b;
      exp_b = (k % 2 == 0) ? 8'h12 : 8'h34;
      chk($sformatf("fill_b%0d", k), {24'b0, q0[k][7:0]}, {24'b0, exp_b});
    end
    repeat (3) @(negedge clk);
    spr_rd(2'd1, r); chk("fill_bytecnt", r, 21);
    spr_rd(2'd0, r); chk("fill_empty", r, 0);
    chk("fill_addr", bus0.vlx_addr_o, 32'h2015);

    // Reset in the middle of a store
    auto0 = 1'b0;
    set_bit(5'd8, 32'h55, st);
    i = 0; while (!bus0.store_byte_o && i < 50) begin @(negedge clk); i++; end
    chk("mid_store", 32'(bus0.store_byte_o), 1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_store", 32'(bus0.store_byte_o), 0);
    chk("rst_mid_stall", 32'(bus0.stall_cpu_o), 0);
    chk("rst_mid_addr", bus0.vlx_addr_o, 0);
    spr_rd(2'd0, r); chk("rst_mid_spr0", r, 0);
    spr_rd(2'd1, r); chk("rst_mid_spr1", r, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_store", 32'(bus0.store_byte_o), 0);
    spr_rd(2'd0, r); chk("post_rst_spr0", r, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
